// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_pipe
// Brief    : Pipelined signed NUM_IN-operand adder tree with valid/ready
//            flow control and whole-pipeline stall.
//            Optional macro ADDER_TREE_PIPE_SAT_EN: saturate instead of wrap
//            when the full-precision sum does not fit OUT_W.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_pipe #(
  parameter int NUM_IN = 4,
  parameter int IN_W   = 28,
  parameter int OUT_W  = IN_W + $clog2(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf_sticky
);

  localparam int C_D  = $clog2(NUM_IN);
  localparam int C_SW = IN_W + C_D;

  // Operand count entering tree level lvl (level 0 sees the raw inputs).
  function automatic int f_cnt(input int lvl);
    int n;
    n = NUM_IN;
    for (int i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  logic              w_adv;
  logic [C_SW-1:0]   w_s;
  logic              w_s_vld;
  logic [OUT_W-1:0]  w_res;
  logic              w_ovf;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar j = 0; j < C_D; j++) begin : g_lvl
    localparam int C_NI = f_cnt(j);
    localparam int C_NO = f_cnt(j + 1);
    localparam int C_WI = IN_W + j;
    localparam int C_WO = IN_W + j + 1;

    logic [C_NI*C_WI-1:0] w_src;
    logic                 w_src_vld;
    logic [C_NO*C_WO-1:0] w_nxt;
    logic [C_NO*C_WO-1:0] r_data;
    logic                 r_vld;

    if (j == 0) begin : g_head
      assign w_src     = in_data;
      assign w_src_vld = in_valid;
    end else begin : g_body
      assign w_src     = g_lvl[j-1].r_data;
      assign w_src_vld = g_lvl[j-1].r_vld;
    end

    for (genvar k = 0; k < C_NO; k++) begin : g_node
      logic [C_WI-1:0] w_a;
      assign w_a = w_src[2*k*C_WI +: C_WI];
      if (2*k + 1 < C_NI) begin : g_pair
        logic [C_WI-1:0] w_b;
        assign w_b = w_src[(2*k+1)*C_WI +: C_WI];
        assign w_nxt[k*C_WO +: C_WO] = {w_a[C_WI-1], w_a} + {w_b[C_WI-1], w_b};
      end else begin : g_pass
        // Unpaired highest operand rides along one level, sign-extended.
        assign w_nxt[k*C_WO +: C_WO] = {w_a[C_WI-1], w_a};
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_src_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_data <= w_nxt;
      end
    end
  end

  if (C_D == 0) begin : g_s_direct
    assign w_s     = in_data;
    assign w_s_vld = in_valid;
  end else begin : g_s_tree
    assign w_s     = g_lvl[C_D-1].r_data;
    assign w_s_vld = g_lvl[C_D-1].r_vld;
  end

  if (OUT_W > C_SW) begin : g_wide
    assign w_res = {{(OUT_W-C_SW){w_s[C_SW-1]}}, w_s};
    assign w_ovf = 1'b0;
  end else if (OUT_W == C_SW) begin : g_exact
    assign w_res = w_s;
    assign w_ovf = 1'b0;
  end else begin : g_narrow
    // The sum fits only if every bit from OUT_W-1 upward equals the sign.
    logic [C_SW-OUT_W:0] w_top;
    assign w_top = w_s[C_SW-1:OUT_W-1];
    assign w_ovf = !((&w_top) || !(|w_top));
`ifdef ADDER_TREE_PIPE_SAT_EN
    assign w_res = !w_ovf       ? w_s[OUT_W-1:0] :
                   w_s[C_SW-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                  {1'b0, {(OUT_W-1){1'b1}}};
`else
    assign w_res = w_s[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_ovf) begin
        ovf_sticky <= 1'b1;
      end
      if (w_adv) begin
        out_valid <= w_s_vld;
        out_data  <= w_res;
        out_ovf   <= w_s_vld && w_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_pipe
// Brief    : Scoreboard bench for adder_tree_pipe: lossless 4x8, overflowing
//            4x8->8 and odd-count 3x8 instances share one handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_pipe;

  typedef struct {
    longint data;
    bit     ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [23:0] c_in = '0;
  logic        a_rdy, b_rdy, c_rdy;
  logic [9:0]  a_out;
  logic [7:0]  b_out;
  logic [9:0]  c_out;
  logic        a_ovf, b_ovf, c_ovf;
  logic        a_vld, b_vld, c_vld;
  logic        a_st, b_st, c_st;

  int     checks = 0;
  int     errors = 0;
  exp_t   sbq [3][$];
  bit     exp_st [3];
  bit     hold [3];
  longint prev_d [3];
  bit     prev_o [3];
  int     run_len = 0;
  int     last_run = 0;
  int     lat;
  string  nm [3] = '{"A", "B", "C"};

  always #5 clk = ~clk;

  adder_tree_pipe #(.NUM_IN(4), .IN_W(8), .OUT_W(10)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in), .in_valid(in_valid), .in_ready(a_rdy),
    .out_data(a_out), .out_ovf(a_ovf), .out_valid(a_vld), .out_ready(out_ready),
    .ovf_sticky(a_st));

  adder_tree_pipe #(.NUM_IN(4), .IN_W(8), .OUT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in), .in_valid(in_valid), .in_ready(b_rdy),
    .out_data(b_out), .out_ovf(b_ovf), .out_valid(b_vld), .out_ready(out_ready),
    .ovf_sticky(b_st));

  adder_tree_pipe #(.NUM_IN(3), .IN_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in), .in_valid(in_valid), .in_ready(c_rdy),
    .out_data(c_out), .out_ovf(c_ovf), .out_valid(c_vld), .out_ready(out_ready),
    .ovf_sticky(c_st));

  function automatic longint op_sum(input logic [31:0] d, input int n);
    longint s;
    s = 0;
    for (int k = 0; k < n; k++) s += longint'($signed(d[k*8 +: 8]));
    return s;
  endfunction

  function automatic exp_t model(input longint s, input int w);
    exp_t   e;
    longint lo;
    longint hi;
    longint m;
    m  = longint'(1) << w;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    e.ovf = (s < lo) || (s > hi);
    if (!e.ovf) begin
      e.data = s;
    end else begin
`ifdef ADDER_TREE_PIPE_SAT_EN
      e.data = (s > 0) ? hi : lo;
`else
      e.data = ((s % m) + m) % m;
      if (e.data > hi) e.data -= m;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    a_in = $urandom();
    b_in = $urandom();
    c_in = 24'($urandom());
  endtask

  // Expected results enter the scoreboard on the edge that accepts the beat.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else if (in_valid) begin
      if (a_rdy) sbq[0].push_back(model(op_sum(a_in, 4), 10));
      if (b_rdy) sbq[1].push_back(model(op_sum(b_in, 4), 8));
      if (c_rdy) sbq[2].push_back(model(op_sum({8'd0, c_in}, 3), 10));
    end
  end

  always @(negedge clk) begin
    bit     v [3];
    longint d [3];
    bit     o [3];
    bit     s [3];
    exp_t   e;
    v = '{a_vld, b_vld, c_vld};
    d = '{longint'($signed(a_out)), longint'($signed(b_out)), longint'($signed(c_out))};
    o = '{a_ovf, b_ovf, c_ovf};
    s = '{a_st, b_st, c_st};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_st[i] = 1'b0;
        hold[i]   = 1'b0;
      end
      run_len = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk({nm[i], " ovf_sticky"}, s[i], exp_st[i]);
        if (hold[i]) begin
          chk({nm[i], " held out_valid"}, v[i], 1);
          chk({nm[i], " held out_data"}, d[i], prev_d[i]);
          chk({nm[i], " held out_ovf"}, o[i], prev_o[i]);
        end
        if (v[i] && out_ready) begin
          checks++;
          if (sbq[i].size() == 0) begin
            errors++;
            $display("FAIL %s unexpected result: got %0d, expected no output", nm[i], d[i]);
          end else begin
            e = sbq[i].pop_front();
            chk({nm[i], " out_data"}, d[i], e.data);
            chk({nm[i], " out_ovf"}, o[i], e.ovf);
            if (e.ovf) exp_st[i] = 1'b1;
          end
        end
        hold[i]   = v[i] && !out_ready;
        prev_d[i] = d[i];
        prev_o[i] = o[i];
      end
      if (v[0]) begin
        run_len++;
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("A out_valid in reset", a_vld, 0);
    chk("A out_data in reset", a_out, 0);
    chk("B ovf_sticky in reset", b_st, 0);
    chk("C out_valid in reset", c_vld, 0);
    rst_n = 1'b1;
    #1;
    chk("A in_ready after reset", a_rdy, 1);
    chk("C in_ready after reset", c_rdy, 1);
    chk("B out_valid after reset", b_vld, 0);
    repeat (2) step();

    // Two directed beats: latency, lossless extremes, overflow, odd count.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_in = {4{8'd127}};
    b_in = {8'd0, 8'd0, 8'd100, 8'd100};
    c_in = {8'd3, 8'hF9, 8'd5};
    step();
    a_in = {4{8'h80}};
    b_in = {4{8'h80}};
    c_in = '0;
    step();
    in_valid = 1'b0;
    lat = 2;
    while (!a_vld && lat < 10) begin
      step();
      lat++;
    end
    chk("A latency", lat, 3);
    chk("A sum 4x127", longint'($signed(a_out)), 508);
    chk("A ovf 4x127", a_ovf, 0);
`ifdef ADDER_TREE_PIPE_SAT_EN
    chk("B overflow data", longint'($signed(b_out)), 127);
`else
    chk("B overflow data", longint'($signed(b_out)), -56);
`endif
    chk("B overflow flag", b_ovf, 1);
    chk("C out_valid odd count", c_vld, 1);
    chk("C sum 5-7+3", longint'($signed(c_out)), 1);
    step();
    chk("A sum 4x-128", longint'($signed(a_out)), -512);
    chk("B ovf_sticky after overflow", b_st, 1);
    chk("A ovf_sticky lossless", a_st, 0);
    repeat (4) step();

    // 20 back-to-back beats must come out as one uninterrupted run.
    for (int n = 0; n < 20; n++) begin
      in_valid = 1'b1;
      rnd();
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("A back-to-back run length", last_run, 20);

    // Fill, then hold out_ready low for 5 cycles with input pending.
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1;
      rnd();
      step();
    end
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      rnd();
      #1;
      chk("A in_ready under backpressure", a_rdy, 0);
      chk("C in_ready under backpressure", c_rdy, 0);
      step();
    end
    out_ready = 1'b1;

    for (int n = 0; n < 150; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 3; i++) chk({nm[i], " scoreboard drained"}, sbq[i].size(), 0);

    // Reset with beats in flight: nothing stale may appear afterwards.
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1;
      rnd();
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("A in_ready after flush", a_rdy, 1);
    chk("A out_valid after flush", a_vld, 0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("A no stale output", a_vld, 0);
      chk("C no stale output", c_vld, 0);
    end
    chk("B ovf_sticky cleared by reset", b_st, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
